// File: rtl/uart_lb_pkg.sv
// Shared register map, bit positions and FSM encoding for the UART loopback master.
package uart_lb_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int DATA_LSB   = 0;
  localparam int DATA_MSB   = 7;
  localparam int WSPACE_LSB = 16;
  localparam int WSPACE_MSB = 31;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DATA,
    ST_WAIT_DATA,
    ST_GAP,
    ST_RD_CTRL,
    ST_WAIT_CTRL,
    ST_WR_DATA
  } lb_state_e;

  function automatic logic [31:0] data_word(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

endpackage

// File: rtl/uart_lb_wait_cnt.sv
// Load/count-down timer: start loads a cycle count, done is high in the last of those cycles.
module uart_lb_wait_cnt
  import uart_lb_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // The load value is a cycle count, so the first waiting cycle already holds load-1.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_i - W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/uart_loopback_master.sv
// Avalon-MM master that polls the UART data register and echoes each received byte
// back through the transmitter once the control register reports TX FIFO space.
module uart_loopback_master
  import uart_lb_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             enable,
  output logic             av_address,
  output logic             av_chipselect,
  output logic [3:0]       av_byteenable,
  output logic             av_read,
  output logic             av_write,
  output logic [31:0]      av_writedata,
  input  logic [31:0]      av_readdata,
  output logic [CNT_W-1:0] echo_count,
  output logic [7:0]       last_byte,
  output logic             busy
);

  localparam int TMR_MAX = (POLL_GAP > READ_LATENCY) ? POLL_GAP : READ_LATENCY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(READ_LATENCY);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(POLL_GAP);

  lb_state_e        state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       last_q, last_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             cs_q, cs_d;
  logic             addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             tmr_start;
  logic [TMR_W-1:0] tmr_load;
  logic             tmr_done;

  logic             rvalid;
  logic [7:0]       rx_byte;
  logic             space_ok;
  logic             unused_rd_bits;

  assign rvalid         = av_readdata[RVALID_BIT];
  assign rx_byte        = av_readdata[DATA_MSB:DATA_LSB];
  assign space_ok       = |av_readdata[WSPACE_MSB:WSPACE_LSB];
  assign unused_rd_bits = ^av_readdata[RVALID_BIT-1:DATA_MSB+1];

  uart_lb_wait_cnt #(
    .W(TMR_W)
  ) u_wait (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .start_i(tmr_start),
    .load_i (tmr_load),
    .done_o (tmr_done)
  );

  // Read data is only trusted in the final cycle of a wait, when tmr_done is high.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    tmr_start = 1'b0;
    tmr_load  = LAT_LOAD;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        state_d   = ST_WAIT_DATA;
        tmr_start = 1'b1;
      end
      ST_WAIT_DATA: begin
        if (tmr_done) begin
          if (rvalid) begin
            hold_d  = rx_byte;
            state_d = ST_RD_CTRL;
          end else if (POLL_GAP > 0) begin
            state_d   = ST_GAP;
            tmr_start = 1'b1;
            tmr_load  = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_CTRL: begin
        state_d   = ST_WAIT_CTRL;
        tmr_start = 1'b1;
      end
      ST_WAIT_CTRL: begin
        if (tmr_done) begin
          state_d = space_ok ? ST_WR_DATA : ST_RD_CTRL;
        end
      end
      ST_WR_DATA: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they register in step with it.
  always_comb begin
    rd_d    = (state_d == ST_RD_DATA) || (state_d == ST_RD_CTRL);
    wr_d    = (state_d == ST_WR_DATA);
    cs_d    = rd_d || wr_d;
    addr_d  = (state_d == ST_RD_CTRL) ? ADDR_CTRL : ADDR_DATA;
    be_d    = cs_d ? BE_ALL : 4'b0000;
    wdata_d = wr_d ? data_word(hold_d) : 32'h0;
    count_d = count_q;
    last_d  = last_q;
    if (state_q == ST_WR_DATA) begin
      count_d = count_q + CNT_W'(1);
      last_d  = hold_q;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'h00;
      count_q <= '0;
      last_q  <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign av_read       = rd_q;
  assign av_write      = wr_q;
  assign av_chipselect = cs_q;
  assign av_address    = addr_q;
  assign av_byteenable = be_q;
  assign av_writedata  = wdata_q;
  assign echo_count    = count_q;
  assign last_byte     = last_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_loopback_master.sv
// Bench for uart_loopback_master: UART slave model plus a transaction-plan predictor checked every cycle.
module tb_uart_loopback_master;

  localparam int RL = 1;
  localparam int PG = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          av_address;
  logic          av_chipselect;
  logic [3:0]    av_byteenable;
  logic          av_read;
  logic          av_write;
  logic [31:0]   av_writedata;
  logic [31:0]   av_readdata = 32'h0;
  logic [CW-1:0] echo_count;
  logic [7:0]    last_byte;
  logic          busy;

  always #5 clk = ~clk;

  uart_loopback_master #(
    .READ_LATENCY(RL),
    .POLL_GAP    (PG),
    .CNT_W       (CW)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .enable       (enable),
    .av_address   (av_address),
    .av_chipselect(av_chipselect),
    .av_byteenable(av_byteenable),
    .av_read      (av_read),
    .av_write     (av_write),
    .av_writedata (av_writedata),
    .av_readdata  (av_readdata),
    .echo_count   (echo_count),
    .last_byte    (last_byte),
    .busy         (busy)
  );

  int errors = 0;
  int checks = 0;

  // UART side of the world: RX bytes waiting and WSPACE answers (64 once exhausted).
  logic [7:0] rx_q[$];
  int         ws_q[$];
  int         rd_age = 9;

  // Bus log
  int          cyc = 0;
  int          n_dread = 0;
  int          n_cread = 0;
  int          n_wr = 0;
  int          wr_cyc = 0;
  logic [31:0] wr_data = 32'h0;
  int          dread_cyc[$];

  // Predictor: expected bus activity for upcoming cycles, one record per cycle.
  typedef struct {
    bit         busy;
    bit         rd;
    bit         wr;
    bit         addr;
    logic [7:0] b;
  } rec_t;

  rec_t          plan[$];
  bit            prev_idle = 1'b1;
  bit            go_edge = 1'b0;
  logic [CW-1:0] m_count = '0;
  logic [7:0]    m_last = 8'h00;
  logic [7:0]    m_hold = 8'h00;

  function automatic rec_t mk(bit bz, bit rd, bit wr, bit ad, logic [7:0] b);
    rec_t r;
    r.busy = bz;
    r.rd   = rd;
    r.wr   = wr;
    r.addr = ad;
    r.b    = b;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_cycle();
    rec_t        e;
    logic [7:0]  rb;
    int          ws;
    bit          exp_cs;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    cyc++;
    // slave answers a read strobe; the answer stays up through the following cycle
    if (av_read) begin
      if (av_address == 1'b0) begin
        if (rx_q.size() > 0) begin
          rb = rx_q.pop_front();
          av_readdata = {16'(rx_q.size()), 1'b1, 7'($urandom), rb};
        end else begin
          av_readdata = {16'h0000, 1'b0, 15'($urandom)};
        end
        n_dread++;
        dread_cyc.push_back(cyc);
        $display("cycle %0d read  data reg -> %h", cyc, av_readdata);
      end else begin
        ws = (ws_q.size() > 0) ? ws_q.pop_front() : 64;
        av_readdata = {16'(ws), 16'($urandom)};
        n_cread++;
        $display("cycle %0d read  ctrl reg -> wspace=%0d", cyc, ws);
      end
      rd_age = 0;
    end else begin
      if (rd_age < 2) rd_age++;
      if (rd_age >= 2) av_readdata = $urandom;
    end
    if (av_write) begin
      n_wr++;
      wr_cyc  = cyc;
      wr_data = av_writedata;
      $display("cycle %0d write addr=%0d data=%h", cyc, av_address, av_writedata);
    end

    e = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    if (!rst_n) begin
      plan.delete();
      m_count   = '0;
      m_last    = 8'h00;
      prev_idle = 1'b1;
    end else begin
      if (plan.size() > 0) begin
        e = plan.pop_front();
      end else if (prev_idle && go_edge) begin
        e = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      end
      prev_idle = !e.busy;
    end

    exp_cs = e.rd | e.wr;
    exp_be = exp_cs ? 4'hF : 4'h0;
    exp_wd = e.wr ? {24'h0, e.b} : 32'h0;
    checks++;
    if (av_read !== e.rd || av_write !== e.wr || av_chipselect !== exp_cs ||
        av_address !== e.addr || av_byteenable !== exp_be || av_writedata !== exp_wd ||
        busy !== e.busy || echo_count !== m_count || last_byte !== m_last) begin
      errors++;
      $display("FAIL bus cycle %0d: got rd=%b wr=%b cs=%b a=%b be=%h wd=%h busy=%b cnt=%0d last=%h; expected rd=%b wr=%b cs=%b a=%b be=%h wd=%h busy=%b cnt=%0d last=%h",
               cyc, av_read, av_write, av_chipselect, av_address, av_byteenable, av_writedata,
               busy, echo_count, last_byte, e.rd, e.wr, exp_cs, e.addr, exp_be, exp_wd,
               e.busy, m_count, m_last);
    end

    if (rst_n) begin
      if (e.wr) begin
        m_count = m_count + CW'(1);
        m_last  = e.b;
      end
      if (e.rd && !e.addr) begin
        repeat (RL) plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        if (av_readdata[15]) begin
          m_hold = av_readdata[7:0];
          plan.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00));
        end else begin
          repeat (PG) plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        end
      end
      if (e.rd && e.addr) begin
        repeat (RL) plan.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        if (av_readdata[31:16] != 16'h0) plan.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, m_hold));
        else plan.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    go_edge = enable && rst_n;
    @(negedge clk);
    bus_cycle();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    rx_q.delete();
    ws_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_writes(int target, int budget, string name);
    int k = 0;
    while (n_wr < target && k < budget) begin
      step();
      k++;
    end
    chk(name, n_wr, target);
  endtask

  task automatic wait_dreads(int target, int budget, string name);
    int k = 0;
    while (n_dread < target && k < budget) begin
      step();
      k++;
    end
    chk(name, n_dread, target);
  endtask

  task automatic wait_creads(int target, int budget, string name);
    int k = 0;
    while (n_cread < target && k < budget) begin
      step();
      k++;
    end
    chk(name, n_cread, target);
  endtask

  initial begin
    int b0, c0, w0, s0, lat, k;
    int gaps[3];

    // reset state
    rst_n = 1'b0;
    step();
    chk("reset_strobes", {av_chipselect, av_read, av_write, av_address, av_byteenable, busy}, 0);
    chk("reset_count", echo_count, 0);
    chk("reset_last", last_byte, 0);

    // single echo of 8'h41
    do_reset();
    rx_q.push_back(8'h41);
    ws_q.push_back(64);
    b0 = n_dread;
    w0 = n_wr;
    enable = 1'b1;
    wait_writes(w0 + 1, 40, "t1_write_seen");
    lat = (dread_cyc.size() > b0) ? (wr_cyc - dread_cyc[b0]) : -1;
    chk("t1_write_cycle", lat, 4);
    chk("t1_wdata", wr_data, 32'h00000041);
    step();
    chk("t1_count", echo_count, 1);
    chk("t1_last", last_byte, 8'h41);
    enable = 1'b0;
    repeat (10) step();

    // empty polls
    do_reset();
    b0 = n_dread;
    w0 = n_wr;
    enable = 1'b1;
    wait_dreads(b0 + 4, 60, "t2_polls_seen");
    for (int i = 0; i < 3; i++) begin
      gaps[i] = (dread_cyc.size() > b0 + i + 1) ? (dread_cyc[b0 + i + 1] - dread_cyc[b0 + i]) : -1;
    end
    chk("t2_gap0", gaps[0], 7);
    chk("t2_gap1", gaps[1], 7);
    chk("t2_gap2", gaps[2], 7);
    chk("t2_no_write", n_wr - w0, 0);
    chk("t2_count", echo_count, 0);
    enable = 1'b0;
    repeat (10) step();

    // TX FIFO full for three control polls
    do_reset();
    rx_q.push_back(8'h5A);
    ws_q = '{0, 0, 0, 1};
    c0 = n_cread;
    w0 = n_wr;
    enable = 1'b1;
    wait_writes(w0 + 1, 60, "t3_write_seen");
    enable = 1'b0;
    chk("t3_ctrl_reads", n_cread - c0, 4);
    chk("t3_wdata", wr_data, 32'h0000005A);
    repeat (10) step();
    chk("t3_single_write", n_wr - w0, 1);
    chk("t3_last", last_byte, 8'h5A);

    // enable dropped right after the byte is latched
    do_reset();
    rx_q.push_back(8'h33);
    b0 = n_dread;
    w0 = n_wr;
    enable = 1'b1;
    wait_dreads(b0 + 1, 20, "t4_read_seen");
    step();
    step();
    enable = 1'b0;
    wait_writes(w0 + 1, 20, "t4_write_seen");
    chk("t4_wdata", wr_data, 32'h00000033);
    step();
    step();
    chk("t4_busy", busy, 0);
    s0 = n_dread + n_cread + n_wr;
    repeat (20) step();
    chk("t4_no_strobes", n_dread + n_cread + n_wr - s0, 0);

    // reset in WAIT_CTRL with a held byte
    do_reset();
    rx_q = '{8'h77, 8'h78};
    ws_q = '{64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    c0 = n_cread;
    enable = 1'b1;
    wait_creads(c0 + 2, 40, "t5_ctrl_seen");
    step();
    chk("t5_pre_count", echo_count, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_strobes", {av_chipselect, av_read, av_write, av_address, av_byteenable, busy}, 0);
    chk("t5_rst_wdata", av_writedata, 0);
    chk("t5_rst_count", echo_count, 0);
    chk("t5_rst_last", last_byte, 0);
    w0 = n_wr;
    repeat (3) step();
    ws_q.delete();
    rx_q.delete();
    rx_q.push_back(8'h99);
    b0 = n_dread;
    c0 = n_cread;
    chk("t5_no_write_in_reset", n_wr - w0, 0);
    rst_n = 1'b1;
    s0 = n_dread + n_cread + n_wr;
    k = 0;
    while (n_dread + n_cread + n_wr == s0 && k < 20) begin
      step();
      k++;
    end
    chk("t5_first_dread", n_dread - b0, 1);
    chk("t5_first_not_ctrl", n_cread - c0, 0);
    chk("t5_first_not_write", n_wr - w0, 0);
    wait_writes(w0 + 1, 30, "t5_echo_after");
    chk("t5_wdata", wr_data, 32'h00000099);
    enable = 1'b0;
    repeat (10) step();

    // counter wrap with a 4-bit count
    do_reset();
    for (int i = 0; i < 17; i++) rx_q.push_back(8'(8'h10 + i));
    w0 = n_wr;
    enable = 1'b1;
    wait_writes(w0 + 17, 400, "t6_writes");
    step();
    chk("t6_count_wrap", echo_count, 1);
    chk("t6_last", last_byte, 8'h20);
    enable = 1'b0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_loopback_master.md
# uart_loopback_master

Avalon-MM master that drives the rs232_0 Avalon slave of the UART subsystem to echo every received byte back out of the transmitter. It sits beside the UART core in the loopback design, polling the data register for received bytes and re-writing each one when the control register reports transmit FIFO space. It also exposes a byte counter and the last echoed byte for debug LEDs and SignalTap.

## Interface
- READ_LATENCY, 1: cycles from the read strobe to valid `av_readdata`; legal range 1-3.
- POLL_GAP, 4: idle cycles inserted after an empty-data poll before the next poll; 0 means no gap.
- CNT_W, 16: width of the echoed-byte counter.

Ports:
- clk_clk  in  1  system clock; same clock as the UART core.
- reset_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run loopback; 0 = finish any held byte, then idle.
- av_address  out  1  0 = data register, 1 = control register.
- av_chipselect  out  1  asserted with every read or write strobe.
- av_byteenable  out  4  always 4'b1111 while chipselect is high, otherwise 0.
- av_read  out  1  single-cycle read strobe.
- av_write  out  1  single-cycle write strobe.
- av_writedata  out  32  {24'h0, byte} on data writes, otherwise 0.
- av_readdata  in  32  slave read data.
- echo_count  out  CNT_W  number of bytes written back; wraps modulo 2^CNT_W.
- last_byte  out  8  most recently echoed byte.
- busy  out  1  high in any state other than IDLE.

## Operation
- Slave register map:
  - Data register (addr 0): [7:0] DATA, [15] RVALID, [31:16] RAVAIL. A read pops the RX FIFO.
  - Control register (addr 1): [31:16] WSPACE.
- FSM states:
  - IDLE: if `enable`, go to RD_DATA.
  - RD_DATA: one-cycle read of addr 0, then WAIT_DATA.
  - WAIT_DATA: count READ_LATENCY cycles, then sample `av_readdata`.
    - RVALID=1: latch DATA into `hold`, go to RD_CTRL.
    - RVALID=0: go to GAP.
  - GAP: wait POLL_GAP cycles, then go to IDLE.
  - RD_CTRL: one-cycle read of addr 1, then WAIT_CTRL.
  - WAIT_CTRL: after READ_LATENCY cycles, sample WSPACE.
    - WSPACE>0: go to WR_DATA.
    - WSPACE=0: go back to RD_CTRL (no gap).
  - WR_DATA: one-cycle write of `hold` to addr 0. Increment `echo_count`, update `last_byte`, go to IDLE.
- Only one transaction is outstanding at a time. The slave has no waitrequest, so every strobe completes in its own cycle.
- Dropping `enable` after a byte has been latched does not lose it: the FSM completes RD_CTRL/WR_DATA first.
- Dropping `enable` in IDLE or GAP stops the FSM at IDLE.
- RAVAIL is ignored; each byte costs one data read.

## Timing
- Reset values: all Avalon outputs 0, `echo_count`=0, `last_byte`=8'h00, `busy`=0, FSM in IDLE. Reset asserts asynchronously mid-transaction. A latched but unwritten byte is discarded.
- Strobes are registered outputs, high for exactly one cycle. `av_address`, `av_byteenable` and `av_writedata` are valid in the same cycle as their strobe.
- Best-case echo with READ_LATENCY=1 and data already waiting, measured from leaving IDLE:
  - RD_DATA (1) + WAIT_DATA (1) + RD_CTRL (1) + WAIT_CTRL (1) + WR_DATA (1) = 5 cycles.
  - Write strobe in cycle 5; IDLE re-entered in cycle 6.
- Empty poll period = 2 + READ_LATENCY−1 + POLL_GAP + 1 cycles.
- `echo_count` wraps from 2^CNT_W−1 to 0 with no flag.
- `readdata` is sampled only in the final WAIT_* cycle and is ignored in every other cycle.

## Structure
- Package `uart_lb_pkg` holds:
  - Register addresses ADDR_DATA and ADDR_CTRL.
  - Bit constants RVALID_BIT=15, DATA_LSB/MSB, WSPACE_LSB/MSB.
  - The FSM state enum.
- One sub-module, `uart_lb_wait_cnt`: a small load/count-down timer shared by WAIT_DATA, WAIT_CTRL and GAP. It has load value, start and done ports.

## Test plan
- Slave model returns RVALID=1, DATA=8'h41, then WSPACE=64. Required:
  - Write at addr 0 with writedata 32'h00000041, 5 cycles after leaving IDLE.
  - `echo_count`=1, `last_byte`=8'h41.
- Slave returns RVALID=0 repeatedly with POLL_GAP=4, READ_LATENCY=1. Required: data reads spaced exactly 7 cycles apart, no writes, `echo_count` stays 0.
- Byte 8'h5A latched, then WSPACE=0 for 3 control reads and 1 on the 4th. Required: exactly 4 control reads, then a single write of 8'h5A.
- `enable` is dropped the cycle after byte 8'h33 is latched. Required: write of 8'h33 still occurs, then `busy`=0 and no further strobes.
- Reset asserted during WAIT_CTRL. Required:
  - All outputs 0 immediately, with no write strobe.
  - After release with `enable`=1, the first strobe is a data read.
- CNT_W=4 and 17 bytes sent. Required: `echo_count`=1 after the 17th write, and `last_byte` equals the 17th byte.
